booth_mul_seq: RTL and testbench



---
 rtl/mul_pkg.sv | 34 +++
 rtl/booth_pp_sel.sv | 40 ++++
 rtl/booth_mul_seq.sv | 112 +++++++++++
 tb/tb_booth_mul_seq.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared types for the sequential Booth multiplier: controller states,
// the one-hot Booth select encoding, and the group count for 32-bit operands.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_e;

    typedef enum logic [4:0] {
        ZERO = 5'b00001,
        PX   = 5'b00010,
        NX   = 5'b00100,
        P2X  = 5'b01000,
        N2X  = 5'b10000
    } booth_sel_e;

    localparam int MUL_ITERS = 17;

    // Radix-4 Booth recoding of one overlapping 3-bit multiplier group.
    function automatic booth_sel_e booth_decode(input logic [2:0] grp);
        booth_sel_e sel;
        case (grp)
            3'b001, 3'b010: sel = PX;
            3'b011:         sel = P2X;
            3'b100:         sel = N2X;
            3'b101, 3'b110: sel = NX;
            default:        sel = ZERO;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/booth_pp_sel.sv
// Booth partial-product selector: picks 0, +-x or +-2x as a sign-extended
// magnitude one bit wider than x. Negative selections are returned as the
// one's complement with neg set; the caller adds the +1 at the right weight.
module booth_pp_sel
    import mul_pkg::*;
#(
    parameter int XW = 33
) (
    input  logic [2:0]    grp,
    input  logic [XW-1:0] x,
    output logic [XW:0]   mag,
    output logic          neg
);

    booth_sel_e sel;

    // Decode the group and select the magnitude / complement.
    always_comb begin
        sel = booth_decode(grp);
        mag = '0;
        neg = 1'b0;
        case (sel)
            PX:  mag = {x[XW-1], x};
            P2X: mag = {x, 1'b0};
            NX:  begin
                mag = ~{x[XW-1], x};
                neg = 1'b1;
            end
            N2X: begin
                mag = ~{x, 1'b0};
                neg = 1'b1;
            end
            default: begin
                mag = '0;
                neg = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/booth_mul_seq.sv
// Iterative radix-4 Booth multiplier for MULT/MULTU: one Booth group per
// cycle accumulated into a 2*DATA_W product, returned over valid/ready.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// BUSY  | accumulating one Booth group per cycle, cnt = group index
// DONE  | product held on result with out_valid until out_ready
module booth_mul_seq
    import mul_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                mul_signed,
    input  logic [DATA_W-1:0]   src1,
    input  logic [DATA_W-1:0]   src2,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*DATA_W-1:0] result,
    output logic                busy
);

    localparam int XW    = DATA_W + 1;
    localparam int YW    = DATA_W + 3;
    localparam int PW    = 2 * DATA_W;
    localparam int ITERS = DATA_W / 2 + 1;
    localparam int CW    = $clog2(ITERS);

    mul_state_e    state, state_nxt;
    logic [XW-1:0] x_r;
    logic [YW-1:0] y_r;
    logic [PW-1:0] acc;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          last;

    logic [2:0]    grp;
    logic [XW:0]   mag;
    logic          neg;
    logic [CW:0]   sh;
    logic [PW-1:0] pp_ext;
    logic [PW-1:0] pp_sh;
    logic [PW-1:0] cin_sh;

    // Group k covers y_r[2k+2:2k]; y_r[0] is the implicit y[-1].
    assign sh   = {cnt, 1'b0};
    assign grp  = y_r[sh +: 3];
    assign last = (cnt == CW'(ITERS - 1));

    booth_pp_sel #(.XW(XW)) u_pp_sel (
        .grp (grp),
        .x   (x_r),
        .mag (mag),
        .neg (neg)
    );

    assign pp_ext = {{(PW-XW-1){mag[XW]}}, mag};
    assign pp_sh  = pp_ext << sh;
    assign cin_sh = {{(PW-1){1'b0}}, neg} << sh;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state and handshake outputs; flush overrides everything.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
        case (state)
            IDLE: if (in_valid && !flush) begin
                state_nxt = BUSY;
                accept    = 1'b1;
            end
            BUSY: if (last) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    // Operand capture, group counter and product accumulation.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_r <= '0;
            y_r <= '0;
            acc <= '0;
            cnt <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (accept) begin
            x_r <= {mul_signed & src1[DATA_W-1], src1};
            y_r <= {{2{mul_signed & src2[DATA_W-1]}}, src2, 1'b0};
            acc <= '0;
            cnt <= '0;
        end else if (state == BUSY) begin
            acc <= acc + pp_sh + cin_sh;
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end

    assign result = acc;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq: directed corner cases with literal
// products, then randomized valid/ready/flush traffic against a cycle-level
// reference built from plain 64-bit multiplication.
module tb_booth_mul_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        mul_signed;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic        busy;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    int          m_left = 0;
    bit          m_done = 1'b0;
    bit          m_idle;
    logic [63:0] m_exp = '0;

    booth_mul_seq #(.DATA_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mul_signed (mul_signed),
        .src1       (src1),
        .src2       (src2),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_mul(input bit s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Reference: a product becomes visible 17 edges after acceptance and
    // stays until taken; reset/flush drop everything.
    always @(posedge clk) begin
        if (reset || flush) begin
            m_left = 0;
            m_done = 1'b0;
        end else if (m_done) begin
            if (out_ready) m_done = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_done = 1'b1;
        end else if (in_valid) begin
            m_left = 17;
            m_exp  = ref_mul(mul_signed, src1, src2);
        end
    end

    // Compare DUT outputs against the reference every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            m_idle = !m_done && (m_left == 0);
            chk("in_ready", 64'(in_ready), 64'(m_idle));
            chk("busy", 64'(busy), 64'(!m_idle));
            chk("out_valid", 64'(out_valid), 64'(m_done));
            if (m_done) chk("result", result, m_exp);
        end
    end

    task automatic run_op(input bit s, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] lit, input int hold);
        int n;
        in_valid   = 1'b1;
        mul_signed = s;
        src1       = a;
        src2       = b;
        @(posedge clk); #1;
        in_valid   = 1'b0;
        src1       = $urandom;
        src2       = $urandom;
        mul_signed = 1'($urandom_range(0, 1));
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", 64'(n), 64'd17);
        chk("lit_result", result, lit);
        repeat (hold) begin
            @(posedge clk); #1;
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_result", result, lit);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("retire_in_ready", 64'(in_ready), 64'd1);
        chk("retire_valid", 64'(out_valid), 64'd0);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; mul_signed = 1'b0;
        src1 = '0; src2 = '0; flush = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", result, 64'd0);
        reset  = 1'b0;
        chk_en = 1'b1;
        @(posedge clk); #1;

        run_op(1'b0, 32'd3, 32'd5, 64'h0000_0000_0000_000F, 0);
        run_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 0);
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0);
        run_op(1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 0);
        run_op(1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000, 0);
        run_op(1'b0, 32'h0000_1234, 32'h0000_5678, 64'h0000_0000_0626_0060, 5);

        // Flush while processing group 8.
        in_valid = 1'b1; mul_signed = 1'b1; src1 = 32'h1357_9BDF; src2 = 32'h2468_ACE0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        chk("flush_valid", 64'(out_valid), 64'd0);
        repeat (20) @(posedge clk);
        #1;
        run_op(1'b1, 32'hFFFF_FFF9, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6, 0);

        // Reset while processing group 4.
        in_valid = 1'b1; mul_signed = 1'b0; src1 = 32'hDEAD_BEEF; src2 = 32'hCAFE_F00D;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_result", result, 64'd0);

        // Flush together with in_valid in IDLE must not accept.
        in_valid = 1'b1; flush = 1'b1; src1 = 32'd9; src2 = 32'd9;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_accept_busy", 64'(busy), 64'd0);
        chk("flush_accept_ready", 64'(in_ready), 64'd1);
        repeat (3) @(posedge clk);
        #1;

        // Randomized traffic with backpressure and occasional flush.
        for (int c = 0; c < 1500; c++) begin
            in_valid   = 1'($urandom_range(0, 1));
            mul_signed = 1'($urandom_range(0, 1));
            src1       = pick();
            src2       = pick();
            out_ready  = ($urandom_range(0, 2) != 0);
            flush      = ($urandom_range(0, 79) == 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        chk("drain_idle", 64'(in_ready), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
